// File: rtl/p4_pkg.sv
// p4_pkg: shared state, opcode and control-code constants for the p4 datapath controller
package p4_pkg;
  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_WRITE_IMM = 3'd2;
  localparam logic [2:0] S_GET_A = 3'd3;
  localparam logic [2:0] S_GET_B = 3'd4;
  localparam logic [2:0] S_ALU = 3'd5;
  localparam logic [2:0] S_WRITE_REG = 3'd6;
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;
  localparam logic [1:0] VSEL_C = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;
endpackage

// File: rtl/p4_instr_dec.sv
// p4_instr_dec: splits the instruction register into fields and instruction-class flags
module p4_instr_dec
  import p4_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic [DW-1:0] ir,
  output logic [RW-1:0] rn,
  output logic [RW-1:0] rd,
  output logic [RW-1:0] rm,
  output logic [1:0]    sh,
  output logic [1:0]    op,
  output logic [DW-1:0] sximm8,
  output logic          is_movi,
  output logic          is_movr,
  output logic          is_add,
  output logic          is_cmp,
  output logic          is_and,
  output logic          is_mvn,
  output logic          is_undef
);
  logic mov, alu;
  assign op = ir[12:11];
  assign rn = ir[10:8];
  assign rd = ir[7:5];
  assign sh = ir[4:3];
  assign rm = ir[2:0];
  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
  assign mov = ir[15:13] == OP_MOV;
  assign alu = ir[15:13] == OP_ALU;
  assign is_movi = mov && op == 2'b10;
  assign is_movr = mov && op == 2'b00;
  assign is_add = alu && op == ALU_ADD;
  assign is_cmp = alu && op == ALU_SUB;
  assign is_and = alu && op == ALU_AND;
  assign is_mvn = alu && op == ALU_NOTB;
  assign is_undef = !(is_movi || is_movr || alu);
endmodule

// File: rtl/p4_datapath_ctrl.sv
// p4_datapath_ctrl: Moore FSM sequencing register reads, ALU, status and write-back per instruction
module p4_datapath_ctrl
  import p4_pkg::*;
#(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic [DW-1:0] instr,
  output logic          w,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic [1:0]    vsel,
  output logic [1:0]    ALUop,
  output logic [1:0]    shift,
  output logic [DW-1:0] sximm8
);
  logic [2:0] state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [RW-1:0] rn, rd, rm;
  logic [1:0] sh, op;
  logic is_movi, is_movr, is_add, is_cmp, is_and, is_mvn, is_undef;
  logic st_wimm, st_geta, st_getb, st_alu, st_wreg;
  p4_instr_dec #(.DW(DW), .RW(RW)) u_dec (
    .ir(ir_q), .rn(rn), .rd(rd), .rm(rm), .sh(sh), .op(op), .sximm8(sximm8),
    .is_movi(is_movi), .is_movr(is_movr), .is_add(is_add), .is_cmp(is_cmp),
    .is_and(is_and), .is_mvn(is_mvn), .is_undef(is_undef)
  );
  always_comb begin
    state_d = S_WAIT;
    ir_d = ir_q;
    case (state_q)
      S_WAIT: begin
        state_d = s ? S_DECODE : S_WAIT;
        ir_d = s ? instr : ir_q;
      end
      S_DECODE: state_d = is_undef ? S_WAIT : is_movi ? S_WRITE_IMM :
                          (is_movr || is_mvn) ? S_GET_B : S_GET_A;
      S_GET_A: state_d = S_GET_B;
      S_GET_B: state_d = S_ALU;
      S_ALU: state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      default: state_d = S_WAIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  assign st_wimm = state_q == S_WRITE_IMM;
  assign st_geta = state_q == S_GET_A;
  assign st_getb = state_q == S_GET_B;
  assign st_alu = state_q == S_ALU;
  assign st_wreg = state_q == S_WRITE_REG;
  assign w = state_q == S_WAIT;
  assign readnum = st_geta ? rn : st_getb ? rm : '0;
  assign writenum = st_wimm ? rn : st_wreg ? rd : '0;
  assign write = st_wimm || st_wreg;
  assign loada = st_geta;
  assign loadb = st_getb;
  assign loadc = st_alu && !is_cmp;
  assign loads = st_alu && is_cmp;
  assign asel = st_alu && (is_movr || is_mvn);
  assign vsel = st_wimm ? VSEL_IMM : VSEL_C;
  assign ALUop = (st_alu && !is_movr) ? op : ALU_ADD;
  assign shift = st_alu ? sh : 2'b00;
endmodule

// File: tb/tb_p4_datapath_ctrl.sv
// tb_p4_datapath_ctrl: table-driven scoreboard bench for the p4 datapath controller
module tb_p4_datapath_ctrl;
  logic clk = 1'b0, reset = 1'b1, s = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic w, write, loada, loadb, loadc, loads, asel;
  logic [2:0] readnum, writenum;
  logic [1:0] vsel, alu_op, shift;
  logic [15:0] sximm8;
  typedef struct packed {
    logic w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic write, loada, loadb, loadc, loads, asel;
    logic [1:0] vsel, aluop, shift;
    logic [15:0] sximm8;
  } out_t;
  typedef struct {
    logic [15:0] ins;
    int lat;
  } vec_t;
  out_t cur, rst_v, e;
  out_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  vec_t vecs[9];
  p4_datapath_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w), .readnum(readnum),
    .writenum(writenum), .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .vsel(vsel), .ALUop(alu_op), .shift(shift), .sximm8(sximm8)
  );
  always #5 clk = ~clk;
  assign cur = {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, vsel, alu_op, shift, sximm8};
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [15:0] ins);
    out_t b, x;
    logic [1:0] op;
    logic mov, alu, movi, movr, cmp, mvn;
    op = ins[12:11];
    mov = ins[15:13] == 3'b110;
    alu = ins[15:13] == 3'b101;
    movi = mov && op == 2'b10;
    movr = mov && op == 2'b00;
    cmp = alu && op == 2'b01;
    mvn = alu && op == 2'b11;
    b = '0;
    b.sximm8 = {{8{ins[7]}}, ins[7:0]};
    exp_q.push_back(b);
    if (movi) begin
      x = b; x.writenum = ins[10:8]; x.vsel = 2'b10; x.write = 1'b1; exp_q.push_back(x);
    end else if (alu || movr) begin
      if (alu && !mvn) begin
        x = b; x.readnum = ins[10:8]; x.loada = 1'b1; exp_q.push_back(x);
      end
      x = b; x.readnum = ins[2:0]; x.loadb = 1'b1; exp_q.push_back(x);
      x = b; x.shift = ins[4:3]; x.aluop = movr ? 2'b00 : op; x.asel = movr || mvn;
      x.loads = cmp; x.loadc = !cmp; exp_q.push_back(x);
      if (!cmp) begin
        x = b; x.writenum = ins[7:5]; x.write = 1'b1; exp_q.push_back(x);
      end
    end
    x = b; x.w = 1'b1; exp_q.push_back(x);
  endfunction
  task automatic run(input vec_t v);
    int low;
    low = 0;
    instr = v.ins;
    s = 1'b1;
    tick();
    s = 1'b0;
    instr = 16'hD0FF;
    model(v.ins);
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("seq_%h_c%0d", v.ins, c), 64'(cur), 64'(e));
      end
      if (w) break;
      low++;
      tick();
    end
    chk($sformatf("lat_%h", v.ins), 64'(low), 64'(v.lat));
    chk($sformatf("left_%h", v.ins), 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask
  initial begin
    int wr;
    vecs[0] = '{16'hD007, 2};
    vecs[1] = '{16'hD1FE, 2};
    vecs[2] = '{16'hA140, 5};
    vecs[3] = '{16'hA908, 4};
    vecs[4] = '{16'hB860, 4};
    vecs[5] = '{16'hC0B3, 4};
    vecs[6] = '{16'hB2FC, 5};
    vecs[7] = '{16'hE000, 1};
    vecs[8] = '{16'hC800, 1};
    rst_v = '0;
    rst_v.w = 1'b1;
    tick();
    tick();
    chk("reset_state", 64'(cur), 64'(rst_v));
    reset = 1'b0;
    tick();
    chk("idle_after_reset", 64'(cur), 64'(rst_v));
    foreach (vecs[i]) run(vecs[i]);
    instr = 16'hA140;
    s = 1'b1;
    tick();
    s = 1'b0;
    tick();
    tick();
    chk("mid_getb", {61'd0, loadb, readnum}, {61'd0, 1'b1, 3'd0});
    reset = 1'b1;
    s = 1'b1;
    instr = 16'hD007;
    tick();
    s = 1'b0;
    reset = 1'b0;
    chk("mid_reset", 64'(cur), 64'(rst_v));
    wr = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      wr += int'(write) + int'(!w);
    end
    chk("post_reset_quiet", 64'(wr), 64'd0);
    instr = 16'hD007;
    s = 1'b1;
    tick();
    for (int r = 0; r < 3; r++) model(16'hD007);
    wr = 0;
    for (int c = 0; c < 9; c++) begin
      e = exp_q.pop_front();
      chk($sformatf("b2b_c%0d", c), 64'(cur), 64'(e));
      wr += int'(write);
      if (c == 8) s = 1'b0;
      tick();
    end
    chk("b2b_writes", 64'(wr), 64'd3);
    chk("b2b_idle", 64'(cur), 64'({1'b1, 18'd0, 16'h0007}));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
